io_bus_ctrl: RTL and testbench

Memory-mapped I/O bus controller between the processor core and its data memory. Passes ordinary loads and stores through to dmem and decodes a small I/O window at the top of the address space. The window holds a parametrised-depth PS/2 scan-code FIFO and a registered LCD output port. All reads, memory or I/O, return with a uniform one-cycle latency.

---
 rtl/io_bus_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O bus controller: dmem pass-through plus a 4-word I/O window
// holding a PS/2 scan-code FIFO and a registered LCD port. All loads return in one cycle.
module io_bus_ctrl #(
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = 32,
   parameter int                KEY_DEPTH = 8,
   parameter logic [ADDR_W-1:0] IO_BASE   = {ADDR_W{1'b1}} - ADDR_W'(3)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_re,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] dmem_address,
   output logic [DATA_W-1:0] dmem_data_in,
   output logic              dmem_wren,
   input  logic [DATA_W-1:0] dmem_q,
   input  logic              ps2_key_pressed,
   input  logic [7:0]        ps2_out,
   output logic              lcd_write,
   output logic [DATA_W-1:0] lcd_data
);

   localparam int PW = $clog2(KEY_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      OFF_KEY_DATA   = 2'd0,
      OFF_KEY_STATUS = 2'd1,
      OFF_LCD_DATA   = 2'd2,
      OFF_KEY_CTRL   = 2'd3
   } io_off_e;

   // ---------------------------------------------------------------------------
   // Address decode and memory pass-through
   // ---------------------------------------------------------------------------
   logic    io_sel;
   io_off_e io_off;
   logic    load;
   logic    io_wr;
   logic    io_rd;

   assign io_sel = (cpu_addr >= IO_BASE);
   // The window is 4 words, so the low two bits of the difference are the offset.
   assign io_off = io_off_e'(cpu_addr[1:0] - IO_BASE[1:0]);
   assign load   = cpu_re & ~cpu_we;
   assign io_wr  = cpu_we & io_sel;
   assign io_rd  = load & io_sel;

   assign dmem_address = cpu_addr;
   assign dmem_data_in = cpu_wdata;
   assign dmem_wren    = cpu_we & ~io_sel;

   // ---------------------------------------------------------------------------
   // PS/2 scan-code FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]    key_mem [KEY_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic          ps2_prev;
   logic          ps2_armed;

   logic empty;
   logic full;
   logic push_req;
   logic pop;
   logic flush;
   logic clr_ovf;
   logic push_ok;
   logic overflow;

   assign empty    = (count == '0);
   assign full     = (count == CW'(KEY_DEPTH));
   // ps2_armed suppresses the false edge seen when the key is held through reset.
   assign push_req = ps2_key_pressed & ~ps2_prev & ps2_armed;
   assign pop      = io_rd & (io_off == OFF_KEY_DATA) & ~empty;
   assign flush    = io_wr & (io_off == OFF_KEY_CTRL) & cpu_wdata[0];
   assign clr_ovf  = io_wr & (io_off == OFF_KEY_CTRL) & cpu_wdata[1];
   assign push_ok  = push_req & ~flush & (~full | pop);
   assign overflow = push_req & ~flush & full & ~pop;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         ps2_prev  <= 1'b0;
         ps2_armed <= 1'b0;
      end else begin
         ps2_prev  <= ps2_key_pressed;
         ps2_armed <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
         if (overflow)     ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
      end
   end

   // NOTE: the code storage has no reset; count and the pointers define which
   // entries are valid, so stale contents are never observable.
   always_ff @(posedge clock) begin
      if (push_ok) key_mem[wr_ptr] <= ps2_out;
   end

   // ---------------------------------------------------------------------------
   // LCD output port
   // ---------------------------------------------------------------------------
   logic lcd_wr;
   assign lcd_wr = io_wr & (io_off == OFF_LCD_DATA);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lcd_write <= 1'b0;
         lcd_data  <= '0;
      end else begin
         lcd_write <= lcd_wr;
         if (lcd_wr) lcd_data <= cpu_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Read path: I/O value is captured with the load; memory data arrives from
   // dmem one cycle later. Result is held until the next load completes.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] io_rdata;
   logic [DATA_W-1:0] rd_io_q;
   logic [DATA_W-1:0] rd_hold;
   logic              rd_pending;
   logic              rd_mem;

   // NOTE: every output of this block gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      io_rdata = '0;
      case (io_off)
         OFF_KEY_DATA: begin
            if (!empty) begin
               io_rdata[DATA_W-1] = 1'b1;
               io_rdata[7:0]      = key_mem[rd_ptr];
            end
         end
         OFF_KEY_STATUS: begin
            io_rdata[DATA_W-1] = ovf;
            io_rdata[CW-1:0]   = count;
         end
         OFF_LCD_DATA: io_rdata = lcd_data;
         default:      io_rdata = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_pending <= 1'b0;
         rd_mem     <= 1'b1;
         rd_io_q    <= '0;
         rd_hold    <= '0;
      end else begin
         rd_pending <= cpu_re;
         if (cpu_re) begin
            // A load colliding with a store completes with zero.
            rd_mem  <= load & ~io_sel;
            rd_io_q <= io_rd ? io_rdata : '0;
         end
         if (rd_pending) rd_hold <= cpu_rdata;
      end
   end

   assign cpu_rdata = rd_pending ? (rd_mem ? dmem_q : rd_io_q) : rd_hold;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: directed scenarios plus randomized bus traffic
// checked against a queue-based reference model.
module tb_io_bus_ctrl;

   localparam int             AW      = 12;
   localparam int             DW      = 32;
   localparam int             KD      = 8;
   localparam logic [AW-1:0]  IO_BASE = 12'hFFC;

   logic          clock;
   logic          reset;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_we;
   logic          cpu_re;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] dmem_address;
   logic [DW-1:0] dmem_data_in;
   logic          dmem_wren;
   logic [DW-1:0] dmem_q;
   logic          ps2_key_pressed;
   logic [7:0]    ps2_out;
   logic          lcd_write;
   logic [DW-1:0] lcd_data;

   io_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .KEY_DEPTH(KD), .IO_BASE(IO_BASE)) dut (
      .clock           (clock),
      .reset           (reset),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_we          (cpu_we),
      .cpu_re          (cpu_re),
      .cpu_rdata       (cpu_rdata),
      .dmem_address    (dmem_address),
      .dmem_data_in    (dmem_data_in),
      .dmem_wren       (dmem_wren),
      .dmem_q          (dmem_q),
      .ps2_key_pressed (ps2_key_pressed),
      .ps2_out         (ps2_out),
      .lcd_write       (lcd_write),
      .lcd_data        (lcd_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous data memory with one-cycle read latency.
   logic [DW-1:0] dmem [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1 << AW); i++) dmem[i] = '0;
      dmem_q = '0;
   end
   always @(posedge clock) begin
      if (dmem_wren) dmem[dmem_address] <= dmem_data_in;
      dmem_q <= dmem[dmem_address];
   end

   // A load result is due in the cycle after cpu_re was high.
   logic re_d;
   always @(posedge clock or negedge reset) begin
      if (!reset) re_d <= 1'b0;
      else        re_d <= cpu_re;
   end

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   logic [7:0]    kq[$];
   bit            m_ovf;
   logic [DW-1:0] m_lcd_next, m_lcd_cur;
   bit            m_lw_next, m_lw_cur;
   bit            m_prev, m_armed;
   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_rd;
   logic [DW-1:0] mon_exp;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares outputs mid-cycle against the model.
   always @(negedge clock) begin
      if (reset) begin
         check("dmem_wren", 32'(dmem_wren), 32'(cpu_we && (cpu_addr < IO_BASE)));
         check("dmem_address", 32'(dmem_address), 32'(cpu_addr));
         check("lcd_write", 32'(lcd_write), 32'(m_lw_cur));
         check("lcd_data", lcd_data, m_lcd_cur);
         if (re_d) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rd_orphan: load result %08h with no expectation", cpu_rdata);
            end else begin
               mon_exp = exp_q.pop_front();
               check("cpu_rdata", cpu_rdata, mon_exp);
               last_rd = mon_exp;
            end
         end else begin
            check("rd_hold", cpu_rdata, last_rd);
         end
      end
   end

   // One bus cycle: drive inputs, advance the model, wait for the clock edge.
   task automatic bus_cycle(input bit we, input bit re, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input bit lvl, input logic [7:0] code);
      bit            io, pop, push, flush, clr, ovf_set;
      logic [1:0]    off;
      logic [DW-1:0] e;
      cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wd;
      ps2_key_pressed = lvl; ps2_out = code;
      io  = (addr >= IO_BASE);
      off = 2'(addr - IO_BASE);
      pop = 0;
      e   = '0;
      if (re) begin
         if (we)       e = '0;
         else if (!io) e = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
         else begin
            case (off)
               2'd0: if (kq.size() > 0) begin e = 32'h8000_0000 | 32'(kq[0]); pop = 1; end
               2'd1: e = {m_ovf, 31'(kq.size())};
               2'd2: e = m_lcd_cur;
               default: e = '0;
            endcase
         end
         exp_q.push_back(e);
      end
      push     = lvl && !m_prev && m_armed;
      m_prev   = lvl;
      m_armed  = 1;
      flush    = we && io && off == 2'd3 && wd[0];
      clr      = we && io && off == 2'd3 && wd[1];
      if (pop) void'(kq.pop_front());
      ovf_set = 0;
      if (push && !flush) begin
         if (kq.size() < KD) kq.push_back(code);
         else                ovf_set = 1;
      end
      if (flush) kq.delete();
      if (ovf_set)  m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_lw_next = we && io && off == 2'd2;
      if (m_lw_next) m_lcd_next = wd;
      if (we && !io) ref_mem[int'(addr)] = wd;
      @(posedge clock);
      m_lw_cur  = m_lw_next;
      m_lcd_cur = m_lcd_next;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus_cycle(0, 0, '0, '0, 0, 8'h00);
   endtask

   task automatic push_code(input logic [7:0] c);
      bus_cycle(0, 0, '0, '0, 1, c);
      bus_cycle(0, 0, '0, '0, 0, 8'h00);
   endtask

   task automatic io_read(input int off);
      bus_cycle(0, 1, IO_BASE + AW'(off), '0, 0, 8'h00);
   endtask

   task automatic io_write(input int off, input logic [DW-1:0] wd);
      bus_cycle(1, 0, IO_BASE + AW'(off), wd, 0, 8'h00);
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      cpu_we = 1'b0;
      cpu_re = 1'b0;
      kq.delete();
      m_ovf = 0; m_lcd_next = '0; m_lcd_cur = '0; m_lw_next = 0; m_lw_cur = 0;
      m_prev = 0; m_armed = 0;
      exp_q.delete();
      last_rd = '0;
      #1;
      check("rst_cpu_rdata", cpu_rdata, '0);
      check("rst_lcd_data", lcd_data, '0);
      check("rst_lcd_write", 32'(lcd_write), '0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 0; cpu_re = 0;
      ps2_key_pressed = 0; ps2_out = '0; last_rd = '0;
      m_lcd_cur = '0; m_lw_cur = 0;
      @(posedge clock); #1;
      do_reset();
      idle(2);
      io_read(1);

      // Memory pass-through
      bus_cycle(1, 0, 12'h010, 32'hDEAD_BEEF, 0, 8'h00);
      bus_cycle(0, 1, 12'h010, '0, 0, 8'h00);
      idle(2);
      bus_cycle(1, 1, 12'h010, 32'h1234_5678, 0, 8'h00);
      bus_cycle(0, 1, 12'h010, '0, 0, 8'h00);
      bus_cycle(0, 1, IO_BASE - 12'd1, '0, 0, 8'h00);

      // FIFO order
      push_code(8'h1C); push_code(8'h32); push_code(8'h21);
      io_read(1);
      io_read(0); io_read(0); io_read(0); io_read(0);
      io_read(1);
      io_write(0, 32'hFFFF_FFFF); io_write(1, 32'hFFFF_FFFF);
      io_read(3);

      // Overflow and clear
      for (int i = 0; i < 9; i++) push_code(8'(8'h40 + i));
      io_read(1);
      io_write(3, 32'h3);
      io_read(1);

      // Push + pop at full, across pointer wrap
      for (int i = 0; i < KD; i++) push_code(8'(8'h60 + i));
      for (int i = 0; i < 10; i++) begin
         bus_cycle(0, 1, IO_BASE, '0, 1, 8'(8'h80 + i));
         io_read(1);
      end
      for (int i = 0; i < KD + 1; i++) io_read(0);
      io_read(1);

      // Push + pop while empty
      bus_cycle(0, 1, IO_BASE, '0, 1, 8'hA5);
      io_read(1);
      bus_cycle(0, 0, '0, '0, 0, 8'h00);

      // Clear-ovf together with an overflow
      io_write(3, 32'h1);
      for (int i = 0; i < KD; i++) push_code(8'(i));
      bus_cycle(1, 0, IO_BASE + 12'd3, 32'h2, 1, 8'hEE);
      io_read(1);
      io_write(3, 32'h3);

      // LCD
      io_write(2, 32'h0000_0041);
      idle(3);
      io_read(2);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         int unsigned op = $urandom_range(0, 9);
         bit          lvl = 1'($urandom_range(0, 1));
         logic [7:0]  code = 8'($urandom);
         logic [AW-1:0] maddr = ($urandom_range(0, 15) == 0) ? IO_BASE - 12'd1 : AW'($urandom_range(0, 31));
         logic [AW-1:0] iaddr = IO_BASE + AW'($urandom_range(0, 3));
         logic [DW-1:0] wd = $urandom;
         case (op)
            0, 1:    bus_cycle(1, 0, maddr, wd, lvl, code);
            2, 3:    bus_cycle(0, 1, maddr, '0, lvl, code);
            4, 5, 6: bus_cycle(0, 1, iaddr, '0, lvl, code);
            7:       bus_cycle(1, 0, iaddr, wd, lvl, code);
            8:       bus_cycle(1, 1, ($urandom_range(0, 1) == 1) ? iaddr : maddr, wd, lvl, code);
            default: bus_cycle(0, 0, '0, '0, lvl, code);
         endcase
      end
      idle(2);

      // Reset mid-stream with the key held high through deassertion
      io_write(3, 32'h3);
      push_code(8'h11); push_code(8'h22); push_code(8'h33);
      io_write(2, 32'h0000_0041);
      bus_cycle(0, 1, 12'h010, '0, 1, 8'h44);
      do_reset();
      bus_cycle(0, 0, '0, '0, 1, 8'h55);
      bus_cycle(0, 0, '0, '0, 1, 8'h55);
      bus_cycle(0, 1, IO_BASE + 12'd1, '0, 1, 8'h55);
      bus_cycle(0, 1, IO_BASE, '0, 1, 8'h55);
      bus_cycle(0, 1, IO_BASE + 12'd2, '0, 1, 8'h55);
      idle(3);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL rd_missing: %0d expected load results never checked", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
